// File: rtl/cmd_stream_arbiter_pkg.sv
// Shared constants and state encoding for the command stream arbiter.
package cmd_stream_arbiter_pkg;

  localparam int CMD_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cmd_stream_arbiter_if.sv
// AXI-Stream command beat bundle; master drives payload, slave drives tready.
interface cmd_stream_arbiter_if
  import cmd_stream_arbiter_pkg::*;
#(
  parameter int DATA_W = CMD_DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/cmd_stream_arbiter_skid_buf.sv
// Two-entry skid buffer with a registered input ready. A beat accepted on one
// edge is presented at the output from the following cycle; with the output
// always ready the occupancy stays at one, giving full throughput.
module axis_skid_buf #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers, occupancy and the registered ready.
  always_comb begin
    push       = in_valid & in_ready_q;
    pop        = out_valid & out_ready;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    count_d    = count_q + 2'(push) - 2'(pop);
    in_ready_d = (count_d != 2'd2);
  end

  // Storage and control registers; ready stays low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/cmd_stream_arbiter.sv
// Packet-atomic arbiter sharing the core command stream between the host (S0,
// fixed priority) and the maintenance generator (S1, bounded wait).
//
// state | meaning
// IDLE  | no owner; registered arbitration decision, no beats accepted
// OWN0  | host owns the stream until its tlast beat is accepted
// OWN1  | maintenance owns the stream until its tlast beat is accepted
module cmd_stream_arbiter
  import cmd_stream_arbiter_pkg::*;
#(
  parameter int DATA_W   = CMD_DATA_W,
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic                enable,
  cmd_stream_arbiter_if.slave  s0_axis_cmd,
  cmd_stream_arbiter_if.slave  s1_axis_cmd,
  cmd_stream_arbiter_if.master m_axis_cmd,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                urgent,
  output logic [CNT_W-1:0]    pkt_cnt0,
  output logic [CNT_W-1:0]    pkt_cnt1
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait1_q, wait1_d;
  logic [CNT_W-1:0]  pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0]  pkt_cnt1_q, pkt_cnt1_d;

  logic              s0_ready, s1_ready;
  logic              s0_last_hs, s1_last_hs;
  logic [DATA_W:0]   skid_in_data;
  logic              skid_in_valid, skid_in_ready;
  logic [DATA_W:0]   skid_out_data;
  logic              skid_out_valid;

  axis_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .in_data   (skid_in_data),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out_data),
    .out_valid (skid_out_valid),
    .out_ready (m_axis_cmd.tready)
  );

  assign s0_axis_cmd.tready = s0_ready;
  assign s1_axis_cmd.tready = s1_ready;
  assign m_axis_cmd.tdata   = skid_out_data[DATA_W-1:0];
  assign m_axis_cmd.tlast   = skid_out_data[DATA_W];
  assign m_axis_cmd.tvalid  = skid_out_valid;

  assign grant    = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign busy     = (state_q != ST_IDLE) | skid_out_valid;
  assign urgent   = (wait1_q == WAIT_MAX);
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;

  // Arbitration, tready steering to the owner only, and packet-end detection.
  always_comb begin
    state_d       = state_q;
    s0_ready      = 1'b0;
    s1_ready      = 1'b0;
    s0_last_hs    = 1'b0;
    s1_last_hs    = 1'b0;
    skid_in_valid = 1'b0;
    skid_in_data  = {s0_axis_cmd.tlast, s0_axis_cmd.tdata};
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (s0_axis_cmd.tvalid && s1_axis_cmd.tvalid)
            state_d = (wait1_q >= WAIT_MAX) ? ST_OWN1 : ST_OWN0;
          else if (s0_axis_cmd.tvalid)
            state_d = ST_OWN0;
          else if (s1_axis_cmd.tvalid)
            state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        s0_ready      = skid_in_ready;
        skid_in_valid = s0_axis_cmd.tvalid;
        if (s0_axis_cmd.tvalid && skid_in_ready && s0_axis_cmd.tlast) begin
          s0_last_hs = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_OWN1: begin
        s1_ready      = skid_in_ready;
        skid_in_valid = s1_axis_cmd.tvalid;
        skid_in_data  = {s1_axis_cmd.tlast, s1_axis_cmd.tdata};
        if (s1_axis_cmd.tvalid && skid_in_ready && s1_axis_cmd.tlast) begin
          s1_last_hs = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // S1 starvation counter (cleared on grant, saturating) and packet counters.
  always_comb begin
    wait1_d = wait1_q;
    if (state_d == ST_OWN1 && state_q != ST_OWN1)
      wait1_d = '0;
    else if (s1_axis_cmd.tvalid && state_q != ST_OWN1 && wait1_q != WAIT_MAX)
      wait1_d = wait1_q + 1'b1;
    pkt_cnt0_d = pkt_cnt0_q + CNT_W'(s0_last_hs);
    pkt_cnt1_d = pkt_cnt1_q + CNT_W'(s1_last_hs);
  end

  // State, wait counter and packet counter registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= ST_IDLE;
      wait1_q    <= '0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      wait1_q    <= wait1_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Directed bench for cmd_stream_arbiter: a per-cycle vector table for the
// basic packet and stall cases, hand sequences for priority/urgency, enable,
// reset and counter wrap, and an in-order beat scoreboard on the output.
// CNT_W is reduced to 8 so the counter wrap is reached in a short run.
module tb_cmd_stream_arbiter;

  localparam int DATA_W   = 128;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 8;
  localparam int CNT_W    = 8;

  logic             axi_aclk = 1'b0;
  logic             axi_aresetn = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       grant;
  logic             busy, urgent;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  cmd_stream_arbiter_if #(.DATA_W(DATA_W)) s0_if ();
  cmd_stream_arbiter_if #(.DATA_W(DATA_W)) s1_if ();
  cmd_stream_arbiter_if #(.DATA_W(DATA_W)) m_if ();

  cmd_stream_arbiter #(
    .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .CNT_W(CNT_W)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .enable      (enable),
    .s0_axis_cmd (s0_if),
    .s1_axis_cmd (s1_if),
    .m_axis_cmd  (m_if),
    .grant       (grant),
    .busy        (busy),
    .urgent      (urgent),
    .pkt_cnt0    (pkt_cnt0),
    .pkt_cnt1    (pkt_cnt1)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic en;
    logic s0_v, s0_l; logic [7:0] s0_t;
    logic s1_v, s1_l; logic [7:0] s1_t;
    logic m_rdy;
    logic [1:0] e_grant;
    logic e_s0_rdy, e_s1_rdy, e_m_v, e_m_l;
    logic [7:0] e_m_t;
    logic e_busy;
  } vec_t;

  function automatic logic [DATA_W-1:0] td(input logic [7:0] t);
    return {16{t}};
  endfunction

  function automatic vec_t vec(input logic en, input logic s0v, input logic s0l,
                               input logic [7:0] s0t, input logic s1v, input logic s1l,
                               input logic [7:0] s1t, input logic mr, input logic [1:0] eg,
                               input logic e0r, input logic e1r, input logic emv,
                               input logic eml, input logic [7:0] emt, input logic eb);
    vec_t v;
    v.en = en; v.s0_v = s0v; v.s0_l = s0l; v.s0_t = s0t;
    v.s1_v = s1v; v.s1_l = s1l; v.s1_t = s1t; v.m_rdy = mr;
    v.e_grant = eg; v.e_s0_rdy = e0r; v.e_s1_rdy = e1r;
    v.e_m_v = emv; v.e_m_l = eml; v.e_m_t = emt; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] t, input logic l);
    beat_t b;
    b.data = td(t);
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Output scoreboard: every accepted M beat must be the next expected one.
  always @(negedge axi_aclk) begin
    if (axi_aresetn && m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL m_beat: got unexpected beat %0h, required none", m_if.tdata);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("m_beat_data", m_if.tdata, b.data);
        chk("m_beat_last", {127'd0, m_if.tlast}, {127'd0, b.last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];

  initial begin
    s0_if.tvalid = 1'b0; s0_if.tlast = 1'b0; s0_if.tdata = '0;
    s1_if.tvalid = 1'b0; s1_if.tlast = 1'b0; s1_if.tdata = '0;
    m_if.tready  = 1'b1;

    // packet through, then 4-beat S1 packet with output stalls
    tbl.push_back(vec(1,1,0,8'h01, 0,0,8'h00, 1, 2'b00,0,0,0,0,8'h00,0));
    tbl.push_back(vec(1,1,0,8'h01, 0,0,8'h00, 1, 2'b01,1,0,0,0,8'h00,1));
    tbl.push_back(vec(1,1,0,8'h02, 0,0,8'h00, 1, 2'b01,1,0,1,0,8'h01,1));
    tbl.push_back(vec(1,1,1,8'h03, 0,0,8'h00, 1, 2'b01,1,0,1,0,8'h02,1));
    tbl.push_back(vec(1,0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,0,1,1,8'h03,1));
    tbl.push_back(vec(1,0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,0,0,0,8'h00,0));
    tbl.push_back(vec(1,0,0,8'h00, 1,0,8'h10, 1, 2'b00,0,0,0,0,8'h00,0));
    tbl.push_back(vec(1,0,0,8'h00, 1,0,8'h10, 1, 2'b10,0,1,0,0,8'h00,1));
    tbl.push_back(vec(1,0,0,8'h00, 1,0,8'h11, 1, 2'b10,0,1,1,0,8'h10,1));
    tbl.push_back(vec(1,0,0,8'h00, 1,0,8'h12, 0, 2'b10,0,1,1,0,8'h11,1));
    tbl.push_back(vec(1,0,0,8'h00, 1,1,8'h13, 0, 2'b10,0,0,1,0,8'h11,1));
    tbl.push_back(vec(1,0,0,8'h00, 1,1,8'h13, 1, 2'b10,0,0,1,0,8'h11,1));
    tbl.push_back(vec(1,0,0,8'h00, 1,1,8'h13, 1, 2'b10,0,1,1,0,8'h12,1));
    tbl.push_back(vec(1,0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,0,1,1,8'h13,1));
    tbl.push_back(vec(1,0,0,8'h00, 0,0,8'h00, 1, 2'b00,0,0,0,0,8'h00,0));

    // Reset values
    #2;
    chk("rst_grant", {126'd0, grant}, '0);
    chk("rst_m_tvalid", {127'd0, m_if.tvalid}, '0);
    chk("rst_busy_urgent", {126'd0, busy, urgent}, '0);
    chk("rst_cnt", {112'd0, pkt_cnt1, pkt_cnt0}, '0);
    tick(); tick();
    axi_aresetn = 1'b1;
    tick(); tick();

    push_exp(8'h01, 0); push_exp(8'h02, 0); push_exp(8'h03, 1);
    push_exp(8'h10, 0); push_exp(8'h11, 0); push_exp(8'h12, 0); push_exp(8'h13, 1);
    foreach (tbl[i]) begin
      enable       = tbl[i].en;
      s0_if.tvalid = tbl[i].s0_v; s0_if.tlast = tbl[i].s0_l; s0_if.tdata = td(tbl[i].s0_t);
      s1_if.tvalid = tbl[i].s1_v; s1_if.tlast = tbl[i].s1_l; s1_if.tdata = td(tbl[i].s1_t);
      m_if.tready  = tbl[i].m_rdy;
      @(negedge axi_aclk);
      chk($sformatf("row%0d grant", i), {126'd0, grant}, {126'd0, tbl[i].e_grant});
      chk($sformatf("row%0d s0_tready", i), {127'd0, s0_if.tready}, {127'd0, tbl[i].e_s0_rdy});
      chk($sformatf("row%0d s1_tready", i), {127'd0, s1_if.tready}, {127'd0, tbl[i].e_s1_rdy});
      chk($sformatf("row%0d m_tvalid", i), {127'd0, m_if.tvalid}, {127'd0, tbl[i].e_m_v});
      chk($sformatf("row%0d busy", i), {127'd0, busy}, {127'd0, tbl[i].e_busy});
      if (tbl[i].e_m_v) begin
        chk($sformatf("row%0d m_tdata", i), m_if.tdata, td(tbl[i].e_m_t));
        chk($sformatf("row%0d m_tlast", i), {127'd0, m_if.tlast}, {127'd0, tbl[i].e_m_l});
      end
      tick();
    end
    chk("tbl_cnt0", {120'd0, pkt_cnt0}, 128'd1);
    chk("tbl_cnt1", {120'd0, pkt_cnt1}, 128'd1);

    // Both sources valid out of reset: S0 first, S1 once its wait hits MAX_WAIT
    axi_aresetn = 1'b0;
    m_if.tready = 1'b1; enable = 1'b1;
    s0_if.tvalid = 1'b1; s0_if.tlast = 1'b0; s0_if.tdata = td(8'h20);
    s1_if.tvalid = 1'b1; s1_if.tlast = 1'b1; s1_if.tdata = td(8'h30);
    push_exp(8'h20, 0); push_exp(8'h21, 0); push_exp(8'h22, 1);
    push_exp(8'h30, 1); push_exp(8'h23, 1);
    tick();
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    chk("prio_idle_grant", {126'd0, grant}, '0);
    tick();
    @(negedge axi_aclk);
    chk("prio_grant_s0", {126'd0, grant}, 128'b01);
    chk("prio_rdy", {126'd0, s1_if.tready, s0_if.tready}, 128'b01);
    tick();
    s0_if.tdata = td(8'h21);
    tick();
    s0_if.tdata = td(8'h22); s0_if.tlast = 1'b1;
    @(negedge axi_aclk);
    chk("prio_urgent_below", {127'd0, urgent}, '0);
    tick();
    s0_if.tdata = td(8'h23);
    @(negedge axi_aclk);
    chk("prio_gap_grant", {126'd0, grant}, '0);
    chk("prio_urgent_set", {127'd0, urgent}, 128'd1);
    chk("prio_cnt0", {120'd0, pkt_cnt0}, 128'd1);
    tick();
    @(negedge axi_aclk);
    chk("prio_grant_s1", {126'd0, grant}, 128'b10);
    chk("prio_urgent_clr", {127'd0, urgent}, '0);
    chk("prio_rdy_s1", {126'd0, s1_if.tready, s0_if.tready}, 128'b10);
    tick();
    s1_if.tvalid = 1'b0;
    @(negedge axi_aclk);
    chk("prio_after_s1", {126'd0, grant}, '0);
    chk("prio_cnt1", {120'd0, pkt_cnt1}, 128'd1);
    tick();
    @(negedge axi_aclk);
    chk("prio_back_s0", {126'd0, grant}, 128'b01);
    tick();
    s0_if.tvalid = 1'b0;
    tick(); tick();
    @(negedge axi_aclk);
    chk("prio_cnt0_end", {120'd0, pkt_cnt0}, 128'd2);
    chk("prio_drained", {127'd0, busy}, '0);
    chk("prio_q_empty", 128'(exp_q.size()), '0);

    // Enable dropped mid S0 packet; pending S1 held until enable returns
    tick();
    push_exp(8'h40, 0); push_exp(8'h41, 0); push_exp(8'h42, 1); push_exp(8'h50, 1);
    s0_if.tvalid = 1'b1; s0_if.tlast = 1'b0; s0_if.tdata = td(8'h40);
    s1_if.tvalid = 1'b1; s1_if.tlast = 1'b1; s1_if.tdata = td(8'h50);
    tick();
    @(negedge axi_aclk);
    chk("en_grant_s0", {126'd0, grant}, 128'b01);
    tick();
    s0_if.tdata = td(8'h41); enable = 1'b0;
    tick();
    s0_if.tdata = td(8'h42); s0_if.tlast = 1'b1;
    @(negedge axi_aclk);
    chk("en_low_continue", {126'd0, grant}, 128'b01);
    tick();
    s0_if.tvalid = 1'b0;
    @(negedge axi_aclk);
    chk("en_low_idle", {126'd0, grant}, '0);
    tick();
    @(negedge axi_aclk);
    chk("en_low_hold", {126'd0, grant}, '0);
    chk("en_low_s1_rdy", {127'd0, s1_if.tready}, '0);
    tick();
    @(negedge axi_aclk);
    chk("en_low_hold2", {126'd0, grant}, '0);
    enable = 1'b1;
    tick();
    @(negedge axi_aclk);
    chk("en_high_s1", {126'd0, grant}, 128'b10);
    tick();
    s1_if.tvalid = 1'b0;
    tick();
    @(negedge axi_aclk);
    chk("en_cnts", {112'd0, pkt_cnt1, pkt_cnt0}, {112'd0, 8'd2, 8'd3});

    // Reset asserted mid-packet
    tick();
    s0_if.tvalid = 1'b1; s0_if.tlast = 1'b0; s0_if.tdata = td(8'h60);
    m_if.tready = 1'b0;
    tick();
    tick();
    s0_if.tdata = td(8'h61);
    @(negedge axi_aclk);
    chk("rstmid_pre_valid", {127'd0, m_if.tvalid}, 128'd1);
    tick();
    axi_aresetn = 1'b0;
    #1;
    chk("rstmid_m_tvalid", {127'd0, m_if.tvalid}, '0);
    chk("rstmid_grant", {126'd0, grant}, '0);
    chk("rstmid_cnts", {112'd0, pkt_cnt1, pkt_cnt0}, '0);
    s0_if.tvalid = 1'b0; m_if.tready = 1'b1;
    tick(); tick();
    axi_aresetn = 1'b1;
    tick(); tick();
    push_exp(8'h70, 0); push_exp(8'h71, 1);
    s0_if.tvalid = 1'b1; s0_if.tlast = 1'b0; s0_if.tdata = td(8'h70);
    tick();
    tick();
    s0_if.tdata = td(8'h71); s0_if.tlast = 1'b1;
    tick();
    s0_if.tvalid = 1'b0;
    tick(); tick();
    @(negedge axi_aclk);
    chk("rstmid_fresh_cnt0", {120'd0, pkt_cnt0}, 128'd1);
    chk("rstmid_q_empty", 128'(exp_q.size()), '0);

    // One-beat S0 packets until pkt_cnt0 wraps
    tick();
    s0_if.tvalid = 1'b1; s0_if.tlast = 1'b1;
    for (int i = 0; i < 255; i++) begin
      s0_if.tdata = td(8'(i));
      push_exp(8'(i), 1);
      tick();
      tick();
      if (i == 253) begin
        @(negedge axi_aclk);
        chk("wrap_cnt0_max", {120'd0, pkt_cnt0}, 128'd255);
      end
    end
    @(negedge axi_aclk);
    chk("wrap_cnt0_zero", {120'd0, pkt_cnt0}, '0);
    s0_if.tvalid = 1'b0;
    tick(); tick();
    @(negedge axi_aclk);
    chk("wrap_cnt1", {120'd0, pkt_cnt1}, '0);
    chk("wrap_q_empty", 128'(exp_q.size()), '0);
    chk("wrap_idle", {125'd0, grant, busy}, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
